// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter and run/flush/done sequencer with cycle counter
module pc_sequencer #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [PC_W-1:0]  StartAddr,
    input  logic             BranchEn,
    input  logic             Taken,
    input  logic [PC_W-1:0]  Target,
    input  logic             Halt,
    input  logic             Stall,
    output logic [PC_W-1:0]  PC,
    output logic             InstrValid,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCount
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [PC_W-1:0]  PC_LAST = {PC_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    // Start overrides everything; otherwise RUN resolves stall > halt > taken branch > sequential.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        done_d  = done_q;
        cnt_d   = cnt_q;
        if (Start) begin
            state_d = S_RUN;
            pc_d    = StartAddr;
            done_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    cnt_d = cnt_inc;
                    if (Stall) begin
                        state_d = S_RUN;
                    end else if (Halt) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (BranchEn && Taken) begin
                        pc_d    = Target;
                        state_d = S_FLUSH;
                    end else if (pc_q == PC_LAST) begin
                        pc_d    = '0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
                S_FLUSH: begin
                    cnt_d   = cnt_inc;
                    state_d = S_RUN;
                end
                default: state_d = state_q;
            endcase
        end
    end

    assign PC         = pc_q;
    assign InstrValid = (state_q == S_RUN);
    assign Done       = done_q;
    assign CycleCount = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized and directed bench for pc_sequencer against a behavioural model
module tb_pc_sequencer;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Start = 1'b0;
    logic [9:0]  StartAddr = '0;
    logic        BranchEn = 1'b0;
    logic        Taken = 1'b0;
    logic [9:0]  Target = '0;
    logic        Halt = 1'b0;
    logic        Stall = 1'b0;
    logic [9:0]  PC;
    logic        InstrValid;
    logic        Done;
    logic [15:0] CycleCount;
    logic [9:0]  PC_s;
    logic        IV_s;
    logic        Done_s;
    logic [3:0]  Cnt_s;

    int checks = 0;
    int errors = 0;

    // model: mode 0 idle, 1 executing, 2 bubble, 3 finished
    int         m_mode = 0;
    int         m_pc = 0;
    int         m_raw = 0;
    bit         m_done = 0;

    pc_sequencer #(.PC_W(10), .CNT_W(16)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .StartAddr(StartAddr),
        .BranchEn(BranchEn), .Taken(Taken), .Target(Target), .Halt(Halt), .Stall(Stall),
        .PC(PC), .InstrValid(InstrValid), .Done(Done), .CycleCount(CycleCount)
    );

    pc_sequencer #(.PC_W(10), .CNT_W(4)) dut_small (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .StartAddr(StartAddr),
        .BranchEn(BranchEn), .Taken(Taken), .Target(Target), .Halt(Halt), .Stall(Stall),
        .PC(PC_s), .InstrValid(IV_s), .Done(Done_s), .CycleCount(Cnt_s)
    );

    always #5 Clk = ~Clk;

    function automatic logic [27:0] model_vec();
        int sat;
        sat = (m_raw > 65535) ? 65535 : m_raw;
        return {m_pc[9:0], (m_mode == 1) ? 1'b1 : 1'b0, m_done, sat[15:0]};
    endfunction

    function automatic logic [3:0] model_small_cnt();
        int sat;
        sat = (m_raw > 15) ? 15 : m_raw;
        return sat[3:0];
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pc = 0; m_raw = 0; m_done = 0;
    endtask

    task automatic model_edge();
        if (Start) begin
            m_mode = 1; m_pc = int'(StartAddr); m_raw = 0; m_done = 0;
        end else if (m_mode == 2) begin
            m_raw++;
            m_mode = 1;
        end else if (m_mode == 1) begin
            m_raw++;
            if (Stall) begin
            end else if (Halt) begin
                m_done = 1; m_mode = 3;
            end else if (BranchEn && Taken) begin
                m_pc = int'(Target); m_mode = 2;
            end else if (m_pc == 1023) begin
                m_pc = 0; m_done = 1; m_mode = 3;
            end else begin
                m_pc = m_pc + 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
    endtask

    task automatic idle_inputs();
        Start = 0; BranchEn = 0; Taken = 0; Halt = 0; Stall = 0;
    endtask

    task automatic test_reset();
        Reset_n = 0;
        model_reset();
        #1;
        checks++;
        if ({PC, InstrValid, Done, CycleCount} !== 28'd0) begin
            errors++;
            $display("FAIL reset_values: got pc=%0d iv=%0b done=%0b cnt=%0d, want all zero", PC, InstrValid, Done, CycleCount);
        end
        @(negedge Clk);
        Reset_n = 1;
        tick();
        checks++;
        if ({PC, InstrValid, Done, CycleCount} !== 28'd0) begin
            errors++;
            $display("FAIL idle_hold: got pc=%0d iv=%0b done=%0b cnt=%0d, want all zero", PC, InstrValid, Done, CycleCount);
        end
    endtask

    task automatic test_start();
        idle_inputs();
        Start = 1; StartAddr = 10'd5;
        tick();
        tick();
        Start = 0;
        checks++;
        if ({PC, InstrValid, Done, CycleCount} !== {10'd5, 1'b1, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL start_load: got pc=%0d iv=%0b done=%0b cnt=%0d, want pc=5 iv=1 done=0 cnt=0", PC, InstrValid, Done, CycleCount);
        end
    endtask

    task automatic test_straight_line();
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (PC !== 10'(5 + i) || InstrValid !== 1'b1) begin
                errors++;
                $display("FAIL straight_pc: got pc=%0d iv=%0b, want pc=%0d iv=1", PC, InstrValid, 5 + i);
            end
        end
        checks++;
        if (CycleCount !== 16'd4) begin
            errors++;
            $display("FAIL straight_cnt: got %0d, want 4", CycleCount);
        end
    endtask

    task automatic test_branch();
        logic [9:0]  exp_pc [3] = '{10'd3, 10'd3, 10'd4};
        logic        exp_iv [3] = '{1'b0, 1'b1, 1'b1};
        BranchEn = 1; Taken = 1; Target = 10'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            BranchEn = 0; Taken = 0;
            checks++;
            if (PC !== exp_pc[i] || InstrValid !== exp_iv[i]) begin
                errors++;
                $display("FAIL taken_branch[%0d]: got pc=%0d iv=%0b, want pc=%0d iv=%0b", i, PC, InstrValid, exp_pc[i], exp_iv[i]);
            end
        end
        Start = 1; StartAddr = 10'd9;
        tick();
        Start = 0; BranchEn = 1; Taken = 0; Target = 10'd3;
        tick();
        BranchEn = 0;
        checks++;
        if (PC !== 10'd10 || InstrValid !== 1'b1) begin
            errors++;
            $display("FAIL not_taken: got pc=%0d iv=%0b, want pc=10 iv=1", PC, InstrValid);
        end
    endtask

    task automatic test_stall_priority();
        logic [15:0] c0;
        idle_inputs();
        Start = 1; StartAddr = 10'd4;
        tick();
        Start = 0;
        c0 = CycleCount;
        Stall = 1; Halt = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (PC !== 10'd4 || InstrValid !== 1'b1 || Done !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got pc=%0d iv=%0b done=%0b, want pc=4 iv=1 done=0", i, PC, InstrValid, Done);
            end
        end
        checks++;
        if (CycleCount !== c0 + 16'd3) begin
            errors++;
            $display("FAIL stall_cnt: got %0d, want %0d", CycleCount, c0 + 16'd3);
        end
        Stall = 0; Halt = 1; BranchEn = 1; Taken = 1; Target = 10'd0;
        tick();
        idle_inputs();
        checks++;
        if ({PC, InstrValid, Done, CycleCount} !== {10'd4, 1'b0, 1'b1, c0 + 16'd4}) begin
            errors++;
            $display("FAIL halt_priority: got pc=%0d iv=%0b done=%0b cnt=%0d, want pc=4 iv=0 done=1 cnt=%0d", PC, InstrValid, Done, CycleCount, c0 + 16'd4);
        end
        BranchEn = 1; Taken = 1; Stall = 1;
        tick();
        tick();
        idle_inputs();
        checks++;
        if ({PC, InstrValid, Done, CycleCount} !== {10'd4, 1'b0, 1'b1, c0 + 16'd4}) begin
            errors++;
            $display("FAIL done_frozen: got pc=%0d iv=%0b done=%0b cnt=%0d, want pc=4 iv=0 done=1 cnt=%0d", PC, InstrValid, Done, CycleCount, c0 + 16'd4);
        end
    endtask

    task automatic test_end_guard();
        Start = 1; StartAddr = 10'd1023;
        tick();
        Start = 0;
        tick();
        checks++;
        if ({PC, InstrValid, Done, CycleCount} !== {10'd0, 1'b0, 1'b1, 16'd1}) begin
            errors++;
            $display("FAIL end_guard: got pc=%0d iv=%0b done=%0b cnt=%0d, want pc=0 iv=0 done=1 cnt=1", PC, InstrValid, Done, CycleCount);
        end
    endtask

    task automatic test_restart_abort();
        Start = 1; StartAddr = 10'd0;
        tick();
        Start = 0;
        checks++;
        if ({PC, InstrValid, Done, CycleCount} !== {10'd0, 1'b1, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL restart: got pc=%0d iv=%0b done=%0b cnt=%0d, want pc=0 iv=1 done=0 cnt=0", PC, InstrValid, Done, CycleCount);
        end
        tick();
        BranchEn = 1; Taken = 1; Target = 10'd7;
        tick();
        idle_inputs();
        #2;
        Reset_n = 0;
        model_reset();
        #1;
        checks++;
        if ({PC, InstrValid, Done, CycleCount} !== 28'd0) begin
            errors++;
            $display("FAIL abort_flush: got pc=%0d iv=%0b done=%0b cnt=%0d, want all zero", PC, InstrValid, Done, CycleCount);
        end
        @(negedge Clk);
        Reset_n = 1;
        tick();
        checks++;
        if (InstrValid !== 1'b0 || PC !== 10'd0) begin
            errors++;
            $display("FAIL abort_idle: got pc=%0d iv=%0b, want pc=0 iv=0", PC, InstrValid);
        end
    endtask

    task automatic test_saturation();
        Start = 1; StartAddr = 10'd0;
        tick();
        Start = 0;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (Cnt_s !== 4'd15 || CycleCount !== 16'd20) begin
            errors++;
            $display("FAIL saturation: got small=%0d wide=%0d, want small=15 wide=20", Cnt_s, CycleCount);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int n = 0; n < 600; n++) begin
            Start     = ($urandom_range(0, 39) == 0) || (m_mode == 3 && $urandom_range(0, 3) == 0);
            StartAddr = ($urandom_range(0, 3) == 0) ? 10'(1020 + $urandom_range(0, 3)) : 10'($urandom);
            Stall     = ($urandom_range(0, 4) == 0);
            Halt      = ($urandom_range(0, 29) == 0);
            BranchEn  = ($urandom_range(0, 3) == 0);
            Taken     = 1'($urandom);
            Target    = ($urandom_range(0, 3) == 0) ? m_pc[9:0] : 10'($urandom);
            tick();
            checks++;
            if ({PC, InstrValid, Done, CycleCount} !== model_vec() || Cnt_s !== model_small_cnt()) begin
                errors++;
                if (bad++ < 10)
                    $display("FAIL random[%0d]: got pc=%0d iv=%0b done=%0b cnt=%0d small=%0d, want vec=%h small=%0d",
                             n, PC, InstrValid, Done, CycleCount, Cnt_s, model_vec(), model_small_cnt());
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_start();
        test_straight_line();
        test_branch();
        test_stall_priority();
        test_end_guard();
        test_restart_abort();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
